// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM and the multicycle datapath.
interface multicycle_main_control_if #(
    parameter int unsigned ST_W = 4
);
    logic [6:0]      op;
    logic            zero;
    logic            pcwrite;
    logic            adrsrc;
    logic            memwrite;
    logic            irwrite;
    logic [1:0]      resultsrc;
    logic [1:0]      alusrca;
    logic [1:0]      alusrcb;
    logic            regwrite;
    logic [1:0]      aluop;
    logic [1:0]      immsrc;
    logic            instr_done;
    logic            illegal_op;
    logic [ST_W-1:0] state;

    // Controller side
    modport master (
        input  op, zero,
        output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
        output regwrite, aluop, immsrc, instr_done, illegal_op, state
    );

    // Datapath side
    modport slave (
        output op, zero,
        input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
        input  regwrite, aluop, immsrc, instr_done, illegal_op, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects and enables.
module multicycle_main_control #(
    parameter int unsigned ST_W = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_main_control_if.master bus
);
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    typedef enum logic [ST_W-1:0] {
        StFetch    = ST_W'(0),
        StDecode   = ST_W'(1),
        StMemAdr   = ST_W'(2),
        StMemRead  = ST_W'(3),
        StMemWb    = ST_W'(4),
        StMemWrite = ST_W'(5),
        StExecuteR = ST_W'(6),
        StAluWb    = ST_W'(7),
        StExecuteI = ST_W'(8),
        StJal      = ST_W'(9),
        StBeq      = ST_W'(10)
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] aluop;
        logic       done;
    } ctrl_t;

    state_t state_q;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;
    logic   legal;
    logic   supported;

    function automatic state_t next_state(input state_t s, input logic [6:0] op);
        state_t n;
        n = StFetch;
        case (s)
            StFetch:  n = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: n = StMemAdr;
                    OpR:        n = StExecuteR;
                    OpI:        n = StExecuteI;
                    OpJal:      n = StJal;
                    OpBeq:      n = StBeq;
                    default:    n = StFetch;
                endcase
            end
            StMemAdr:   n = (op == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  n = StMemWb;
            StExecuteR: n = StAluWb;
            StExecuteI: n = StAluWb;
            StJal:      n = StAluWb;
            default:    n = StFetch;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            StDecode: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            StMemAdr: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            StMemRead: c.adrsrc = 1'b1;
            StMemWb: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
                c.done      = 1'b1;
            end
            StMemWrite: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
                c.done     = 1'b1;
            end
            StExecuteR: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b10;
            end
            StExecuteI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = 2'b10;
            end
            StAluWb: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            StJal: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            StBeq: begin
                c.alusrca = 2'b10;
                c.aluop   = 2'b01;
                c.branch  = 1'b1;
                c.done    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // State register with outputs registered alongside; reset lands in FETCH
    // with FETCH selects so the first edge after release executes FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_for(StFetch);
        end else begin
            state_q <= next_state(state_q, bus.op);
            ctrl_q  <= ctrl_for(next_state(state_q, bus.op));
        end
    end

    // Unreachable codes silence every output
    assign legal = (state_q <= StBeq);
    assign ctrl  = legal ? ctrl_q : '0;

    assign supported = (bus.op == OpLw) || (bus.op == OpSw) || (bus.op == OpR) ||
                       (bus.op == OpI) || (bus.op == OpBeq) || (bus.op == OpJal);

    // Write enables are gated by rst_n so a reset aborts writes in the same cycle
    assign bus.pcwrite    = rst_n & (ctrl.pcupdate | (ctrl.branch & bus.zero));
    assign bus.irwrite    = rst_n & ctrl.irwrite;
    assign bus.memwrite   = rst_n & ctrl.memwrite;
    assign bus.regwrite   = rst_n & ctrl.regwrite;
    assign bus.instr_done = rst_n & ctrl.done;
    assign bus.adrsrc     = ctrl.adrsrc;
    assign bus.resultsrc  = ctrl.resultsrc;
    assign bus.alusrca    = ctrl.alusrca;
    assign bus.alusrcb    = ctrl.alusrcb;
    assign bus.aluop      = ctrl.aluop;
    assign bus.illegal_op = (state_q == StDecode) & ~supported;
    assign bus.state      = state_q;

    // Immediate format follows the opcode in every legal state
    always_comb begin
        bus.immsrc = 2'b00;
        if (legal) begin
            case (bus.op)
                OpSw:    bus.immsrc = 2'b01;
                OpBeq:   bus.immsrc = 2'b10;
                OpJal:   bus.immsrc = 2'b11;
                default: bus.immsrc = 2'b00;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: an instruction-level model predicts the
// state path and per-state outputs; a negedge compare process checks them.
module tb_multicycle_main_control;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRead = 3, SMemWb = 4;
    localparam int SMemWrite = 5, SExecR = 6, SAluWb = 7, SExecI = 8, SJal = 9, SBeq = 10;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] aluop;
        logic [1:0] immsrc;
        logic       instr_done;
        logic       illegal_op;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   exp_q[$];

    multicycle_main_control_if #(.ST_W(4)) bus ();

    multicycle_main_control #(.ST_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OpLw) || (op == OpSw) || (op == OpR) || (op == OpI) ||
               (op == OpBeq) || (op == OpJal);
    endfunction

    // Outputs the rules demand for a given state, opcode and zero flag
    function automatic exp_t model_out(input int s, input logic [6:0] op, input logic z);
        exp_t e;
        logic pcupd;
        logic br;
        e = '0;
        pcupd = 1'b0;
        br = 1'b0;
        e.state = 4'(s);
        case (s)
            SFetch:    begin e.irwrite = 1; pcupd = 1; e.alusrcb = 2; e.resultsrc = 2; end
            SDecode:   begin e.alusrca = 1; e.alusrcb = 1; end
            SMemAdr:   begin e.alusrca = 2; e.alusrcb = 1; end
            SMemRead:  e.adrsrc = 1;
            SMemWb:    begin e.resultsrc = 1; e.regwrite = 1; end
            SMemWrite: begin e.adrsrc = 1; e.memwrite = 1; end
            SExecR:    begin e.alusrca = 2; e.aluop = 2; end
            SExecI:    begin e.alusrca = 2; e.alusrcb = 1; e.aluop = 2; end
            SAluWb:    e.regwrite = 1;
            SJal:      begin e.alusrca = 1; e.alusrcb = 2; pcupd = 1; end
            SBeq:      begin e.alusrca = 2; e.aluop = 1; br = 1; end
            default: ;
        endcase
        e.pcwrite    = pcupd | (br & z);
        e.instr_done = (s == SMemWb) || (s == SMemWrite) || (s == SAluWb) || (s == SBeq);
        e.illegal_op = (s == SDecode) && !is_supported(op);
        if (op == OpSw)       e.immsrc = 2'b01;
        else if (op == OpBeq) e.immsrc = 2'b10;
        else if (op == OpJal) e.immsrc = 2'b11;
        else                  e.immsrc = 2'b00;
        return e;
    endfunction

    // Per-cycle compare against the model while expectations are queued
    always @(negedge clk) begin
        int   s;
        exp_t e;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            s = exp_q.pop_front();
            e = model_out(s, bus.op, bus.zero);
            chk("state",      32'(bus.state),      32'(e.state));
            chk("pcwrite",    32'(bus.pcwrite),    32'(e.pcwrite));
            chk("adrsrc",     32'(bus.adrsrc),     32'(e.adrsrc));
            chk("memwrite",   32'(bus.memwrite),   32'(e.memwrite));
            chk("irwrite",    32'(bus.irwrite),    32'(e.irwrite));
            chk("resultsrc",  32'(bus.resultsrc),  32'(e.resultsrc));
            chk("alusrca",    32'(bus.alusrca),    32'(e.alusrca));
            chk("alusrcb",    32'(bus.alusrcb),    32'(e.alusrcb));
            chk("regwrite",   32'(bus.regwrite),   32'(e.regwrite));
            chk("aluop",      32'(bus.aluop),      32'(e.aluop));
            chk("immsrc",     32'(bus.immsrc),     32'(e.immsrc));
            chk("instr_done", 32'(bus.instr_done), 32'(e.instr_done));
            chk("illegal_op", 32'(bus.illegal_op), 32'(e.illegal_op));
            if (bus.instr_done === 1'b1) done_seen++;
        end
    end

    // Called just after a rising edge with the DUT in FETCH
    task automatic run_instr(input logic [6:0] op_v, input logic z, input int len_lit,
                             input int done_lit, input string name);
        int seq[$];
        int d0;
        seq = '{SFetch, SDecode};
        if (op_v == OpLw)       seq = '{SFetch, SDecode, SMemAdr, SMemRead, SMemWb};
        else if (op_v == OpSw)  seq = '{SFetch, SDecode, SMemAdr, SMemWrite};
        else if (op_v == OpR)   seq = '{SFetch, SDecode, SExecR, SAluWb};
        else if (op_v == OpI)   seq = '{SFetch, SDecode, SExecI, SAluWb};
        else if (op_v == OpJal) seq = '{SFetch, SDecode, SJal, SAluWb};
        else if (op_v == OpBeq) seq = '{SFetch, SDecode, SBeq};
        chk({name, " cycles"}, 32'(seq.size()), 32'(len_lit));
        bus.op = op_v;
        bus.zero = z;
        d0 = done_seen;
        foreach (seq[i]) exp_q.push_back(seq[i]);
        repeat (seq.size()) @(posedge clk);
        #1;
        chk({name, " done pulses"}, 32'(done_seen - d0), 32'(done_lit));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.op = 7'b0;
        bus.zero = 1'b0;

        // Reset hold: FETCH selects visible, write enables suppressed
        repeat (3) begin
            @(negedge clk);
            chk("rst state",     32'(bus.state),      32'd0);
            chk("rst pcwrite",   32'(bus.pcwrite),    32'd0);
            chk("rst irwrite",   32'(bus.irwrite),    32'd0);
            chk("rst regwrite",  32'(bus.regwrite),   32'd0);
            chk("rst memwrite",  32'(bus.memwrite),   32'd0);
            chk("rst alusrcb",   32'(bus.alusrcb),    32'd2);
            chk("rst resultsrc", 32'(bus.resultsrc),  32'd2);
            chk("rst done",      32'(bus.instr_done), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post-rst irwrite", 32'(bus.irwrite), 32'd1);
        chk("post-rst pcwrite", 32'(bus.pcwrite), 32'd1);

        run_instr(OpLw,  1'b0, 5, 1, "lw");
        run_instr(OpR,   1'b1, 4, 1, "r-type");
        run_instr(OpI,   1'b0, 4, 1, "i-alu");
        run_instr(OpBeq, 1'b1, 3, 1, "beq taken");
        run_instr(OpBeq, 1'b0, 3, 1, "beq not taken");
        run_instr(OpJal, 1'b0, 4, 1, "jal");
        run_instr(OpSw,  1'b1, 4, 1, "sw");
        run_instr(7'b1111111, 1'b0, 2, 0, "illegal ones");
        run_instr(7'b0000000, 1'b1, 2, 0, "illegal zeros");

        // Hand-pinned beq: pcwrite follows zero within the BEQ cycle
        bus.op = OpBeq;
        bus.zero = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("beq pin state",   32'(bus.state),   32'd10);
        chk("beq pin aluop",   32'(bus.aluop),   32'd1);
        chk("beq pin immsrc",  32'(bus.immsrc),  32'd2);
        chk("beq pin pcwrite", 32'(bus.pcwrite), 32'd1);
        #1 bus.zero = 1'b0;
        #1 chk("beq pin pcwrite z0", 32'(bus.pcwrite), 32'd0);
        @(posedge clk);
        #1;

        // Hand-pinned lw, aborted by reset during MEMWB
        bus.op = OpLw;
        @(negedge clk);
        chk("lw pin fetch", 32'(bus.state), 32'd0);
        @(negedge clk);
        chk("lw pin decode", 32'(bus.state), 32'd1);
        @(negedge clk);
        chk("lw pin memadr alusrca", 32'(bus.alusrca), 32'd2);
        @(negedge clk);
        chk("lw pin memread adrsrc", 32'(bus.adrsrc), 32'd1);
        @(negedge clk);
        chk("lw pin memwb state",    32'(bus.state),     32'd4);
        chk("lw pin memwb regwrite", 32'(bus.regwrite),  32'd1);
        chk("lw pin memwb result",   32'(bus.resultsrc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort regwrite", 32'(bus.regwrite),   32'd0);
        chk("abort state",    32'(bus.state),      32'd0);
        chk("abort done",     32'(bus.instr_done), 32'd0);
        chk("abort irwrite",  32'(bus.irwrite),    32'd0);
        chk("abort alusrcb",  32'(bus.alusrcb),    32'd2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(OpLw, 1'b0, 5, 1, "lw after reset");
        run_instr(OpJal, 1'b1, 4, 1, "jal after reset");
        exp_q.push_back(SFetch);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM of the multicycle RV32I core. It sits directly upstream of alu_decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath mux selects and write enables, plus the 2-bit aluop that alu_decoder expands into alu_control.
- Also produces immsrc for the immediate extender and status pulses for instruction retire and illegal opcode.

Parameters:
- ST_W, 4: width of the state register. Must be at least 4 to hold all 11 states.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  7  opcode field, instr[6:0], from the instruction register
- zero  input  1  ALU zero flag
- pcwrite  output  1  PC register enable
- adrsrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register and OldPC enable
- resultsrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alusrca  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- alusrcb  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- regwrite  output  1  register file write enable
- aluop  output  2  to alu_decoder: 00 = add, 01 = subtract, 10 = use funct fields
- immsrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal_op  output  1  high in DECODE when op is unsupported
- state  output  ST_W  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Reset: while rst_n=0, state=FETCH asynchronously. pcwrite, irwrite, memwrite and regwrite are forced to 0. All other outputs take their FETCH values.
- The first active edge after rst_n rises executes FETCH normally.
- Supported opcodes: lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE -> MEMADR for lw or sw; EXECUTER for R; EXECUTEI for I-ALU; JAL for jal; BEQ for beq. Any other op -> FETCH, with illegal_op=1 during that DECODE cycle.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw. op is held stable by the instruction register.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Per-state outputs (Moore; any output not listed is 0):
  - FETCH: irwrite=1, pcupdate=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, adrsrc=0.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. This precomputes the branch target.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: resultsrc=00, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=10.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
- pcwrite = pcupdate OR (branch AND zero). This is combinational on zero within the same cycle; pcupdate and branch are internal.
- immsrc is decoded combinationally from op in every state: lw and I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, otherwise 00.
- instr_done=1 in MEMWB, MEMWRITE, ALUWB and BEQ. It is never asserted during reset.
- Cycle counts:
  - lw: 5 cycles
  - sw, R, I-ALU and jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Reset mid-instruction: the block returns to FETCH immediately and aborts any write enable in the same cycle. No partial writeback is permitted.

Test Plan:
- Reset and hold: rst_n=0 for 3 cycles, then release -> during reset state=0, all write enables 0, alusrcb=10, resultsrc=10. Cycle 1 after release: irwrite=1, pcwrite=1.
- lw (op=0000011): states 0,1,2,3,4,0. regwrite=1 and resultsrc=01 only in state 4. immsrc=00. instr_done exactly once.
- R then I (op=0110011, then 0010011): states 0,1,6,7, then 0,1,8,7. aluop=10 in states 6 and 8. alusrcb=00 in 6, 01 in 8. regwrite in 7 only.
- beq with zero=1, then beq with zero=0: in state 10, aluop=01 and immsrc=10. pcwrite=1 in the first case, 0 in the second. Each path is 3 cycles.
- jal and sw: jal gives states 0,1,9,7 with pcwrite=1 in 9 and immsrc=11. sw gives 0,1,2,5 with memwrite=1 and adrsrc=1 in 5 only, and immsrc=01.
- Illegal opcode and reset mid-operation: op=1111111 -> illegal_op=1 in DECODE, next state 0, no writes. Assert rst_n=0 during MEMWB of a lw -> regwrite drops immediately and state=0 asynchronously.
